kirby_anim_sequencer: RTL and testbench

- Produces the per-pixel-independent animation state `character_action_idx` and `character_action_frame_idx` that the sprite frame mapper consumes.
- Accepts action requests from the character control logic with a valid/ready handshake.
- Paces frame advance on the once-per-video-frame tick and handles looping versus one-shot actions.
- Sits between the Kirby movement/control FSM and the sprite frame mapper/ROM address logic.

---
 rtl/kirby_anim_pkg.sv | 51 +++++
 rtl/kirby_anim_sequencer_if.sv | 25 ++
 rtl/anim_hold_counter.sv | 27 ++
 rtl/kirby_anim_sequencer.sv | 109 ++++++++++
 tb/tb_kirby_anim_sequencer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/kirby_anim_pkg.sv
// Shared animation tables and types for the Kirby sprite sequencer and frame mapper.
// Latency: n/a (constants only). Backpressure: n/a.
package kirby_anim_pkg;

    localparam int NUM_ACT = 3;
    localparam int ACT_W   = 3;
    localparam int FRAME_W = 4;
    localparam int HOLD_W  = 4;

    typedef enum logic [ACT_W-1:0] {
        ACT_IDLE = 3'd0,
        ACT_WALK = 3'd1,
        ACT_JUMP = 3'd2
    } action_e;

    typedef enum logic [1:0] {
        ST_PLAY_LOOP,
        ST_PLAY_ONESHOT,
        ST_DONE
    } anim_state_e;

    localparam logic [FRAME_W-1:0] FRAME_COUNT [NUM_ACT] = '{4'd2, 4'd10, 4'd10};
    localparam logic [HOLD_W-1:0]  HOLD_TICKS  [NUM_ACT] = '{4'd8, 4'd4, 4'd3};
    localparam logic               LOOP_FLAG   [NUM_ACT] = '{1'b1, 1'b1, 1'b0};

    // Unknown rows fall back to the idle row so lookups never index off the table.
    function automatic logic [FRAME_W-1:0] frame_count(input logic [ACT_W-1:0] a);
        case (a)
            ACT_WALK: return FRAME_COUNT[1];
            ACT_JUMP: return FRAME_COUNT[2];
            default:  return FRAME_COUNT[0];
        endcase
    endfunction

    function automatic logic [HOLD_W-1:0] hold_ticks(input logic [ACT_W-1:0] a);
        case (a)
            ACT_WALK: return HOLD_TICKS[1];
            ACT_JUMP: return HOLD_TICKS[2];
            default:  return HOLD_TICKS[0];
        endcase
    endfunction

    function automatic logic is_loop(input logic [ACT_W-1:0] a);
        case (a)
            ACT_WALK: return LOOP_FLAG[1];
            ACT_JUMP: return LOOP_FLAG[2];
            default:  return LOOP_FLAG[0];
        endcase
    endfunction

endpackage

// File: rtl/kirby_anim_sequencer_if.sv
// Action request handshake plus the animation state handed to the frame mapper.
// Latency: n/a (wiring). Backpressure: action_req_ready from the sequencer.
interface kirby_anim_sequencer_if;
    import kirby_anim_pkg::*;

    logic [ACT_W-1:0]   action_req;
    logic               action_req_valid;
    logic               action_req_ready;
    logic [ACT_W-1:0]   character_action_idx;
    logic [FRAME_W-1:0] character_action_frame_idx;
    logic               frame_changed;
    logic               anim_done;

    modport master (
        output action_req, action_req_valid,
        input  action_req_ready, character_action_idx, character_action_frame_idx,
               frame_changed, anim_done
    );

    modport slave (
        input  action_req, action_req_valid,
        output action_req_ready, character_action_idx, character_action_frame_idx,
               frame_changed, anim_done
    );
endinterface

// File: rtl/anim_hold_counter.sv
// Per-frame hold counter; wraps to zero after reaching a runtime limit.
// Latency: tc is combinational from the registered count. Backpressure: none.
module anim_hold_counter #(
    parameter int W = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);
    logic [W-1:0] cnt;

    // >= keeps the counter from running away if the limit shrinks mid-count.
    assign tc = (cnt >= (limit - W'(1)));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end
endmodule

// File: rtl/kirby_anim_sequencer.sv
// Steps the sprite action/frame indices on video-frame ticks; loops or plays one-shots.
// Latency: registered outputs, accepted request visible 1 cycle after accept.
// Backpressure: ready is low while a one-shot plays and during its completion cycle.
module kirby_anim_sequencer
    import kirby_anim_pkg::*;
#(
    parameter int NUM_ACTIONS    = 3,
    parameter int HOLD_W         = 4,
    parameter int DEFAULT_ACTION = 0
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     frame_clk_rising,
    input  logic                     freeze,
    kirby_anim_sequencer_if.slave    bus
);
    anim_state_e        state, state_nxt;
    logic [ACT_W-1:0]   action, action_nxt;
    logic [FRAME_W-1:0] frame, frame_nxt;
    logic               frame_changed, frame_changed_nxt;
    logic               anim_done, anim_done_nxt;
    logic               hold_clr, hold_en, hold_tc;
    logic               accept, tick;
    logic [FRAME_W-1:0] last_frame;

    localparam logic [ACT_W-1:0] DEF_ACT = ACT_W'(DEFAULT_ACTION);

    assign bus.action_req_ready           = (state == ST_PLAY_LOOP);
    assign bus.character_action_idx       = action;
    assign bus.character_action_frame_idx = frame;
    assign bus.frame_changed              = frame_changed;
    assign bus.anim_done                  = anim_done;

    // Out-of-range requests still complete the handshake but never count as accepts.
    assign accept     = bus.action_req_valid & bus.action_req_ready &
                        (bus.action_req < ACT_W'(NUM_ACTIONS));
    assign tick       = frame_clk_rising & ~freeze & ~accept;
    assign last_frame = frame_count(action) - FRAME_W'(1);

    anim_hold_counter #(.W(HOLD_W)) u_hold (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clr     (hold_clr),
        .en      (hold_en),
        .limit   (HOLD_W'(hold_ticks(action))),
        .tc      (hold_tc)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= ST_PLAY_LOOP;
            action        <= DEF_ACT;
            frame         <= '0;
            frame_changed <= 1'b0;
            anim_done     <= 1'b0;
        end else begin
            state         <= state_nxt;
            action        <= action_nxt;
            frame         <= frame_nxt;
            frame_changed <= frame_changed_nxt;
            anim_done     <= anim_done_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        action_nxt        = action;
        frame_nxt         = frame;
        frame_changed_nxt = 1'b0;
        anim_done_nxt     = 1'b0;
        hold_clr          = 1'b0;
        hold_en           = 1'b0;
        case (state)
            ST_DONE: begin
                action_nxt        = DEF_ACT;
                frame_nxt         = '0;
                hold_clr          = 1'b1;
                frame_changed_nxt = 1'b1;
                anim_done_nxt     = 1'b1;
                state_nxt         = ST_PLAY_LOOP;
            end
            default: begin
                if (accept) begin
                    if (bus.action_req != action) begin
                        action_nxt        = bus.action_req;
                        frame_nxt         = '0;
                        hold_clr          = 1'b1;
                        frame_changed_nxt = 1'b1;
                        state_nxt         = is_loop(bus.action_req) ? ST_PLAY_LOOP
                                                                    : ST_PLAY_ONESHOT;
                    end
                end else if (tick) begin
                    hold_en = 1'b1;
                    if (hold_tc) begin
                        if (frame < last_frame) begin
                            frame_nxt         = frame + FRAME_W'(1);
                            frame_changed_nxt = 1'b1;
                        end else if (is_loop(action)) begin
                            frame_nxt         = '0;
                            frame_changed_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_DONE;
                        end
                    end
                end
            end
        endcase
    end
endmodule

// File: tb/tb_kirby_anim_sequencer.sv
module tb_kirby_anim_sequencer;
    logic Clk;
    logic Reset_n;
    logic frame_clk_rising;
    logic freeze;
    int   vectors;
    int   errors;

    kirby_anim_sequencer_if bus ();

    kirby_anim_sequencer #(
        .NUM_ACTIONS    (3),
        .HOLD_W         (4),
        .DEFAULT_ACTION (0)
    ) dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .frame_clk_rising (frame_clk_rising),
        .freeze           (freeze),
        .bus              (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int act, input int frm, input int fc,
                           input int done, input int rdy);
        chk({tag, " action"}, int'(bus.character_action_idx), act);
        chk({tag, " frame"},  int'(bus.character_action_frame_idx), frm);
        chk({tag, " frame_changed"}, int'(bus.frame_changed), fc);
        chk({tag, " anim_done"}, int'(bus.anim_done), done);
        chk({tag, " ready"}, int'(bus.action_req_ready), rdy);
    endtask

    // One clock edge, optionally with a frame tick; sample 1 time unit after the edge.
    task automatic step(input logic tk);
        frame_clk_rising = tk;
        @(posedge Clk);
        #1;
        frame_clk_rising = 1'b0;
    endtask

    initial begin
        vectors              = 0;
        errors               = 0;
        Reset_n              = 1'b0;
        freeze               = 1'b0;
        frame_clk_rising     = 1'b0;
        bus.action_req       = '0;
        bus.action_req_valid = 1'b0;

        #12;
        chk_all("reset", 0, 0, 0, 0, 1);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Idle: 2 frames, 8 ticks per frame.
        for (int t = 1; t <= 16; t++) begin
            step(1'b1);
            chk_all($sformatf("idle t%0d", t), 0, (t >= 8 && t < 16) ? 1 : 0,
                    (t == 8 || t == 16) ? 1 : 0, 0, 1);
        end
        step(1'b0);
        chk("idle quiet frame_changed", int'(bus.frame_changed), 0);

        // Walk: 10 frames, 4 ticks per frame, loops.
        bus.action_req = 3'd1; bus.action_req_valid = 1'b1;
        step(1'b0);
        bus.action_req_valid = 1'b0;
        chk_all("walk accept", 1, 0, 1, 0, 1);
        for (int t = 1; t <= 40; t++) begin
            step(1'b1);
            chk_all($sformatf("walk t%0d", t), 1, (t / 4) % 10, (t % 4 == 0) ? 1 : 0, 0, 1);
        end

        // Jump: one-shot, 10 frames x 3 ticks; a walk request is held throughout.
        bus.action_req = 3'd2; bus.action_req_valid = 1'b1;
        step(1'b0);
        bus.action_req = 3'd1;
        chk_all("jump accept", 2, 0, 1, 0, 0);
        for (int t = 1; t <= 30; t++) begin
            step(1'b1);
            chk_all($sformatf("jump t%0d", t), 2, (t < 30) ? t / 3 : 9,
                    (t < 30 && t % 3 == 0) ? 1 : 0, 0, 0);
        end
        step(1'b1);
        chk_all("jump done", 0, 0, 1, 1, 1);
        step(1'b0);
        bus.action_req_valid = 1'b0;
        chk_all("held walk accepted", 1, 0, 1, 0, 1);

        // Out-of-range request is consumed with no effect.
        bus.action_req = 3'd5; bus.action_req_valid = 1'b1;
        step(1'b0);
        bus.action_req_valid = 1'b0;
        chk_all("req 5 ignored", 1, 0, 0, 0, 1);

        // Back to idle, partly fill the hold counter, then request + tick together.
        bus.action_req = 3'd0; bus.action_req_valid = 1'b1;
        step(1'b0);
        bus.action_req_valid = 1'b0;
        chk_all("idle accept", 0, 0, 1, 0, 1);
        for (int t = 1; t <= 3; t++) begin
            step(1'b1);
            chk_all($sformatf("idle pre t%0d", t), 0, 0, 0, 0, 1);
        end
        bus.action_req = 3'd1; bus.action_req_valid = 1'b1;
        step(1'b1);
        bus.action_req_valid = 1'b0;
        chk_all("accept beats tick", 1, 0, 1, 0, 1);
        for (int t = 1; t <= 4; t++) begin
            step(1'b1);
            chk_all($sformatf("walk hold restart t%0d", t), 1, (t == 4) ? 1 : 0,
                    (t == 4) ? 1 : 0, 0, 1);
        end

        // Freeze blocks ticks but not accepts.
        freeze = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            step(1'b1);
            chk_all($sformatf("freeze t%0d", t), 1, 1, 0, 0, 1);
        end
        bus.action_req = 3'd0; bus.action_req_valid = 1'b1;
        step(1'b1);
        bus.action_req_valid = 1'b0;
        freeze = 1'b0;
        chk_all("accept under freeze", 0, 0, 1, 0, 1);

        // Same looping action requested again: no restart, no pulse.
        for (int t = 1; t <= 5; t++) step(1'b1);
        bus.action_req = 3'd0; bus.action_req_valid = 1'b1;
        step(1'b0);
        bus.action_req_valid = 1'b0;
        chk_all("same action", 0, 0, 0, 0, 1);
        step(1'b1);
        step(1'b1);
        chk_all("same action keeps hold", 0, 0, 0, 0, 1);
        step(1'b1);
        chk_all("same action frame 1", 0, 1, 1, 0, 1);

        // Asynchronous reset mid-animation, then a clean restart.
        bus.action_req = 3'd1; bus.action_req_valid = 1'b1;
        step(1'b0);
        bus.action_req_valid = 1'b0;
        for (int t = 1; t <= 6; t++) step(1'b1);
        #3;
        Reset_n = 1'b0;
        #1;
        chk_all("async reset", 0, 0, 0, 0, 1);
        #2;
        Reset_n = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            step(1'b1);
            chk($sformatf("restart frame t%0d", t), int'(bus.character_action_frame_idx),
                (t == 8) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
